// File: rtl/async_arb_pkg.sv
// Shared types and default sizing for the asynchronous-request round-robin arbiter.
`timescale 1ns/1ps
package async_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {IDLE, GRANT, ACK, RELEASE} arb_state_t;

endpackage

// File: rtl/req_sync.sv
// Two-flop synchronizer bringing one raw request line into the clk domain.
`timescale 1ns/1ps
module req_sync (
  input  logic clk,
  input  logic n_rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/async_req_arbiter.sv
// Round-robin arbiter sharing one synchronous resource between NUM_REQ asynchronous
// requesters using a 4-phase req/ack handshake, with a grant timeout.
`timescale 1ns/1ps
module async_req_arbiter
  import async_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int IDW     = $clog2(NUM_REQ),
  localparam int TOW     = $clog2(TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [NUM_REQ-1:0] async_req,
  output logic [NUM_REQ-1:0] ack,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IDW-1:0]     grant_id,
  input  logic               svc_done,
  output logic               timeout_err
);

  localparam logic [TOW-1:0] TIMER_LAST = TOW'(TIMEOUT - 1);

  arb_state_t         state, next_state;
  logic [NUM_REQ-1:0] sreq;
  logic [IDW-1:0]     win_id, win_id_d;
  logic [IDW-1:0]     last, last_d;
  logic [IDW-1:0]     pick;
  logic [TOW-1:0]     timer, timer_d;
  logic [NUM_REQ-1:0] grant_d, ack_d;
  logic [IDW-1:0]     grant_id_d;
  logic               grant_valid_d, timeout_err_d;

  // Searching downward leaves the bit nearest to last+1 as the final assignment.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                             input logic [IDW-1:0]     prev);
    logic [IDW-1:0] sel;
    logic [IDW-1:0] idx;
    sel = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = IDW'((int'(prev) + i) % NUM_REQ);
      if (req[idx]) sel = idx;
    end
    return sel;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] id);
    logic [NUM_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_sync
    req_sync u_sync (
      .clk   (clk),
      .n_rst (n_rst),
      .d     (async_req[g]),
      .q     (sreq[g])
    );
  end

  assign pick = rr_pick(sreq, last);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state       <= IDLE;
      win_id      <= '0;
      last        <= IDW'(NUM_REQ - 1);
      timer       <= '0;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      ack         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= next_state;
      win_id      <= win_id_d;
      last        <= last_d;
      timer       <= timer_d;
      grant       <= grant_d;
      grant_id    <= grant_id_d;
      grant_valid <= grant_valid_d;
      ack         <= ack_d;
      timeout_err <= timeout_err_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|sreq) next_state = GRANT;
      GRANT:   if (svc_done || timer == TIMER_LAST) next_state = ACK;
      ACK:     if (!sreq[win_id]) next_state = RELEASE;
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs; done takes precedence over timeout.
  always_comb begin
    win_id_d      = win_id;
    last_d        = last;
    timer_d       = timer;
    grant_d       = grant;
    grant_id_d    = grant_id;
    ack_d         = ack;
    timeout_err_d = 1'b0;
    case (state)
      IDLE: begin
        if (|sreq) begin
          win_id_d   = pick;
          grant_d    = onehot(pick);
          grant_id_d = pick;
          timer_d    = '0;
        end
      end
      GRANT: begin
        if (svc_done || timer == TIMER_LAST) begin
          grant_d       = '0;
          grant_id_d    = '0;
          ack_d         = onehot(win_id);
          timeout_err_d = !svc_done;
        end else begin
          timer_d = timer + TOW'(1);
        end
      end
      ACK: begin
        if (!sreq[win_id]) begin
          ack_d  = '0;
          last_d = win_id;
        end
      end
      default: ;
    endcase
    grant_valid_d = |grant_d;
  end

endmodule

// File: tb/tb_async_req_arbiter.sv
// Scoreboard bench for async_req_arbiter: directed stimulus pushes expected grant/ack
// events, a negedge monitor pops and compares them as the DUT raises grant or ack.
`timescale 1ns/100ps
module tb_async_req_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 8;

  logic       clk       = 1'b0;
  logic       n_rst     = 1'b0;
  logic       svc_done  = 1'b0;
  logic [3:0] async_req = 4'b0000;
  logic [3:0] ack;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       timeout_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         is_ack;
    logic [3:0] vec;
    logic [1:0] id;
    logic       terr;
  } exp_t;

  exp_t exp_q[$];

  logic [3:0] prev_grant = 4'b0000;
  logic [3:0] prev_ack   = 4'b0000;

  always #5 clk = ~clk;

  async_req_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .async_req   (async_req),
    .ack         (ack),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .svc_done    (svc_done),
    .timeout_err (timeout_err)
  );

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic done, input logic rst_n);
    async_req = req;
    svc_done  = done;
    n_rst     = rst_n;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushGrant(input logic [1:0] idx);
    exp_q.push_back(exp_t'{is_ack: 1'b0, vec: 4'b0001 << idx, id: idx, terr: 1'b0});
  endtask

  task automatic pushAck(input logic [1:0] idx, input logic terr);
    exp_q.push_back(exp_t'{is_ack: 1'b1, vec: 4'b0001 << idx, id: idx, terr: terr});
  endtask

  task automatic waitGrant(input string name, input int budget);
    int n = 0;
    while (!grant_valid && n < budget) begin
      tick();
      n++;
    end
    checkOutput(name, 8'(grant_valid), 8'h01);
  endtask

  task automatic waitAck(input string name, input logic [1:0] idx, input logic level, input int budget);
    int n = 0;
    while (ack[idx] !== level && n < budget) begin
      tick();
      n++;
    end
    checkOutput(name, 8'(ack[idx]), 8'(level));
  endtask

  task automatic rrStep(input logic [1:0] idx, input bit push_grant, input bit reraise);
    if (push_grant) pushGrant(idx);
    waitGrant("rr grant", 12);
    checkOutput("rr grant_id", 8'(grant_id), 8'(idx));
    pushAck(idx, 1'b0);
    svc_done = 1'b1;
    tick();
    svc_done = 1'b0;
    waitAck("rr ack high", idx, 1'b1, 5);
    async_req[idx] = 1'b0;
    waitAck("rr ack low", idx, 1'b0, 10);
    if (reraise) async_req[idx] = 1'b1;
  endtask

  // Counts edges from the toggle of async_req[3] until grant[3] is first seen high.
  task automatic measureLatency(input bit before_edge, output int edges);
    edges = 0;
    if (before_edge) begin
      #8.9;
      async_req[3] = 1'b1;
    end else begin
      @(posedge clk);
      #0.1;
      async_req[3] = 1'b1;
      edges = 1;
    end
    while (!grant[3] && edges < 8) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    total++;
    if (!($onehot0(grant) && $onehot0(ack) && !(|grant && |ack) && grant_valid == |grant)) begin
      bad++;
      $display("[TB] FAIL invariant: grant=%b ack=%b grant_valid=%b at %0t", grant, ack, grant_valid, $time);
    end
    if (|grant && prev_grant == 4'b0000) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected grant: got grant=%b id=%0d expected no event", grant, grant_id);
      end else begin
        e = exp_q.pop_front();
        if (e.is_ack || grant !== e.vec || grant_id !== e.id) begin
          bad++;
          $display("[TB] FAIL grant event: got grant=%b id=%0d expected is_ack=%0d vec=%b id=%0d",
                   grant, grant_id, e.is_ack, e.vec, e.id);
        end
      end
    end
    if (|ack && prev_ack == 4'b0000) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected ack: got ack=%b terr=%b expected no event", ack, timeout_err);
      end else begin
        e = exp_q.pop_front();
        if (!e.is_ack || ack !== e.vec || timeout_err !== e.terr) begin
          bad++;
          $display("[TB] FAIL ack event: got ack=%b terr=%b expected is_ack=%0d vec=%b terr=%b",
                   ack, timeout_err, e.is_ack, e.vec, e.terr);
        end
      end
    end
    prev_grant = grant;
    prev_ack   = ack;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int edges;

    // Reset held with all requests asserted.
    applyStimulus(4'b1111, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset grant", 8'(grant), 8'h00);
    checkOutput("reset ack", 8'(ack), 8'h00);
    checkOutput("reset grant_id", 8'(grant_id), 8'h00);
    checkOutput("reset timeout_err", 8'(timeout_err), 8'h00);
    checkOutput("reset grant_valid", 8'(grant_valid), 8'h00);
    pushGrant(2'd0);
    n_rst = 1'b1;
    tick();
    tick();
    checkOutput("post-reset grant edge2", 8'(grant), 8'h00);
    tick();
    checkOutput("post-reset grant edge3", 8'(grant), 8'h01);
    checkOutput("post-reset grant_id", 8'(grant_id), 8'h00);

    // Round robin with every requester active: order 0,1,2,3 then wrap to 0.
    rrStep(2'd0, 1'b0, 1'b1);
    rrStep(2'd1, 1'b1, 1'b1);
    rrStep(2'd2, 1'b1, 1'b1);
    rrStep(2'd3, 1'b1, 1'b0);
    async_req = 4'b0001;
    rrStep(2'd0, 1'b1, 1'b0);
    repeat (4) tick();
    checkOutput("rr quiet", 8'(grant), 8'h00);

    // Single request and 4-phase handshake timing.
    applyStimulus(4'b0100, 1'b0, 1'b1);
    pushGrant(2'd2);
    tick();
    tick();
    checkOutput("single grant edge2", 8'(grant), 8'h00);
    tick();
    checkOutput("single grant edge3", 8'(grant), 8'h04);
    checkOutput("single grant_id", 8'(grant_id), 8'h02);
    pushAck(2'd2, 1'b0);
    svc_done = 1'b1;
    tick();
    svc_done = 1'b0;
    checkOutput("single ack", 8'(ack), 8'h04);
    checkOutput("single grant dropped", 8'(grant), 8'h00);
    async_req = 4'b0000;
    tick();
    tick();
    checkOutput("single ack held", 8'(ack), 8'h04);
    tick();
    checkOutput("single ack released", 8'(ack), 8'h00);
    repeat (3) tick();

    // Timeout on requester 1: grant held exactly TIMEOUT cycles.
    applyStimulus(4'b0010, 1'b0, 1'b1);
    pushGrant(2'd1);
    pushAck(2'd1, 1'b1);
    repeat (3) tick();
    checkOutput("timeout grant", 8'(grant), 8'h02);
    repeat (7) tick();
    checkOutput("timeout grant held", 8'(grant), 8'h02);
    tick();
    checkOutput("timeout grant dropped", 8'(grant), 8'h00);
    checkOutput("timeout_err pulse", 8'(timeout_err), 8'h01);
    checkOutput("timeout ack", 8'(ack), 8'h02);
    tick();
    checkOutput("timeout_err cleared", 8'(timeout_err), 8'h00);
    checkOutput("timeout ack held", 8'(ack), 8'h02);
    async_req = 4'b0000;
    waitAck("timeout ack low", 2'd1, 1'b0, 10);
    repeat (3) tick();

    // svc_done on the timeout cycle wins; svc_done in IDLE is ignored.
    applyStimulus(4'b1000, 1'b0, 1'b1);
    pushGrant(2'd3);
    pushAck(2'd3, 1'b0);
    repeat (3) tick();
    checkOutput("collision grant", 8'(grant), 8'h08);
    checkOutput("collision grant_id", 8'(grant_id), 8'h03);
    repeat (7) tick();
    svc_done = 1'b1;
    tick();
    svc_done = 1'b0;
    checkOutput("collision grant dropped", 8'(grant), 8'h00);
    checkOutput("collision ack", 8'(ack), 8'h08);
    checkOutput("collision no timeout_err", 8'(timeout_err), 8'h00);
    tick();
    checkOutput("collision timeout_err later", 8'(timeout_err), 8'h00);
    async_req = 4'b0000;
    waitAck("collision ack low", 2'd3, 1'b0, 10);
    repeat (3) tick();
    svc_done = 1'b1;
    tick();
    svc_done = 1'b0;
    checkOutput("idle done grant", 8'(grant), 8'h00);
    checkOutput("idle done ack", 8'(ack), 8'h00);
    checkOutput("idle done timeout_err", 8'(timeout_err), 8'h00);
    repeat (3) tick();
    checkOutput("idle done quiet", 8'(grant_valid), 8'h00);

    // Request toggled just before an edge; same requester wins again.
    pushGrant(2'd3);
    pushAck(2'd3, 1'b0);
    measureLatency(1'b1, edges);
    checkOutput("setup latency", 8'(edges == 3 || edges == 4), 8'h01);
    tick();
    tick();
    checkOutput("setup grant stable", 8'(grant), 8'h08);
    svc_done = 1'b1;
    tick();
    svc_done = 1'b0;
    waitAck("setup ack high", 2'd3, 1'b1, 5);
    async_req = 4'b0000;
    waitAck("setup ack low", 2'd3, 1'b0, 10);
    repeat (3) tick();

    // Request toggled just after an edge, then reset mid-GRANT.
    pushGrant(2'd3);
    measureLatency(1'b0, edges);
    checkOutput("hold latency", 8'(edges == 3 || edges == 4), 8'h01);
    tick();
    checkOutput("hold grant stable", 8'(grant), 8'h08);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    tick();
    checkOutput("midreset grant", 8'(grant), 8'h00);
    checkOutput("midreset ack", 8'(ack), 8'h00);
    checkOutput("midreset grant_id", 8'(grant_id), 8'h00);
    checkOutput("midreset grant_valid", 8'(grant_valid), 8'h00);
    checkOutput("midreset timeout_err", 8'(timeout_err), 8'h00);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    tick();
    n_rst = 1'b1;
    repeat (4) tick();
    checkOutput("final idle", 8'(grant), 8'h00);

    @(negedge clk);
    @(negedge clk);
    checkOutput("scoreboard drained", 8'(exp_q.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
